// File: rtl/seg_scan_rx_pkg.sv
// Shared types and glyph decoding for the 7-segment bus receiver.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SAMPLE_W   = 12;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       seg_p;
  } sample_t;

  // Active-high gfedcba, index = nibble value (15 down to 0).
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [4:0] glyph_to_nibble(input logic [6:0] g);
    glyph_to_nibble = 5'b0;
    for (int i = 0; i < 16; i++)
      if (g == GLYPHS[i]) glyph_to_nibble = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/seg_scan_rx_if.sv
// Multiplexed 7-segment display bus, all signals active-low.
interface seg_scan_rx_if;
  logic [3:0] AN;
  logic [6:0] seg;
  logic       seg_P;

  modport master (output AN, seg, seg_P);
  modport slave  (input  AN, seg, seg_P);
endinterface

// File: rtl/seg_scan_rx_stable_filter.sv
// Two-flop synchronizer plus a saturating stability counter; accept fires once per stable run.
module stable_filter #(
  parameter int WIDTH         = 12,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             accept
);
  localparam logic [7:0] TOP = 8'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, prev;
  logic [7:0]       cnt;
  logic             match;

  assign match = (s2 == prev);
  // Combinational so the consumer registers its outputs on the very edge cnt hits TOP.
  assign accept = match && (cnt == TOP - 8'd1);
  assign dout   = prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
      cnt  <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      if (!match)          cnt <= '0;
      else if (cnt != TOP) cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/seg_scan_rx.sv
// Bus monitor: decodes accepted digit samples and reassembles the displayed 16-bit value.
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_rx_if.slave  bus,
  output logic [15:0]   dat,
  output logic [3:0]    dp,
  output logic          frame_valid,
  output logic          bad
);
  sample_t raw, smp;
  logic    accept;

  assign raw = {bus.AN, bus.seg, bus.seg_P};

  stable_filter #(.WIDTH(SAMPLE_W), .STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk    (clk),
    .reset  (reset),
    .din    (raw),
    .dout   (smp),
    .accept (accept)
  );

  logic [4:0] gl;
  logic       blank, onehot;
  logic [1:0] idx;

  assign gl    = glyph_to_nibble(~smp.seg);
  assign blank = (smp.an == 4'hF);

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (smp.an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  logic [NUM_DIGITS-1:0][3:0] sh_nib, nxt_nib;
  logic [NUM_DIGITS-1:0]      sh_dp, nxt_dp, seen, nxt_seen;

  // Shadow as it would look with the current sample folded in; completion copies this.
  always_comb begin
    nxt_nib  = sh_nib;
    nxt_dp   = sh_dp;
    nxt_seen = seen;
    nxt_nib[idx]  = gl[3:0];
    nxt_dp[idx]   = ~smp.seg_p;
    nxt_seen[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_nib      <= '0;
      sh_dp       <= '0;
      seen        <= '0;
      dat         <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      bad         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      bad         <= 1'b0;
      if (accept && !blank) begin
        if (!onehot) begin
          bad <= 1'b1;
        end else if (!gl[4]) begin
          bad       <= 1'b1;
          seen[idx] <= 1'b0;
        end else begin
          sh_nib <= nxt_nib;
          sh_dp  <= nxt_dp;
          if (&nxt_seen) begin
            dat         <= nxt_nib;
            dp          <= nxt_dp;
            frame_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= nxt_seen;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_rx.sv
// Scoreboard bench for seg_scan_rx: a digit-level model predicts frames and bad pulses.
module tb_seg_scan_rx;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dat;
  logic [3:0]  dp;
  logic        frame_valid, bad;

  seg_scan_rx_if bus_if();

  seg_scan_rx #(.STABLE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .dat         (dat),
    .dp          (dp),
    .frame_valid (frame_valid),
    .bad         (bad)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  logic [6:0] gtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [19:0] exp_q [$];
  int          exp_bad = 0, exp_fv = 0;
  logic [15:0] m_dat = '0;
  logic [3:0]  m_dp = '0, m_seen = '0;
  logic [3:0]  p_an = 4'hF;
  logic [6:0]  p_g = 7'h00;
  logic        p_p = 1'b1;
  int          run = 0;
  bit          fired = 0;

  int  cyc = 0, last_fv = 0, n_fv = 0, n_bad = 0;
  bit  per_en = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_valid) begin
      logic [19:0] e;
      n_fv++;
      chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("frame_dat", 32'(dat), 32'(e[19:4]));
        chk("frame_dp", 32'(dp), 32'(e[3:0]));
      end
      chk("fv_bad_overlap", 32'(bad), 32'd0);
      if (per_en) chk("frame_period", 32'(cyc - last_fv), 32'd80);
      last_fv = cyc;
    end
    if (bad) n_bad++;
  end

  task automatic model_accept(input logic [3:0] an, input logic [6:0] g, input logic p);
    int k, v;
    k = -1;
    v = -1;
    case (an)
      4'b1110: k = 0;
      4'b1101: k = 1;
      4'b1011: k = 2;
      4'b0111: k = 3;
      default: k = -1;
    endcase
    if (an == 4'hF) return;
    if (k < 0) begin
      exp_bad++;
      return;
    end
    for (int i = 0; i < 16; i++) if (gtab[i] == g) v = i;
    if (v < 0) begin
      exp_bad++;
      m_seen[k] = 1'b0;
    end else begin
      m_dat[4*k +: 4] = 4'(v);
      m_dp[k]   = ~p;
      m_seen[k] = 1'b1;
      if (&m_seen) begin
        exp_q.push_back({m_dat, m_dp});
        exp_fv++;
        m_seen = '0;
      end
    end
  endtask

  // g is the active-high glyph; pins carry its complement.
  task automatic step(input logic [3:0] an, input logic [6:0] g, input logic p, input int c);
    if (an !== p_an || g !== p_g || p !== p_p) begin
      run   = 0;
      fired = 0;
    end
    p_an = an; p_g = g; p_p = p;
    run += c;
    if (!fired && run >= N) begin
      fired = 1;
      model_accept(an, g, p);
    end
    bus_if.AN    = an;
    bus_if.seg   = ~g;
    bus_if.seg_P = p;
    repeat (c) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] a;
    a = 4'hF;
    a[k] = 1'b0;
    return a;
  endfunction

  task automatic digit(input int k, input logic [3:0] nib, input logic p);
    step(an_of(k), gtab[nib], p, 20);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] pm);
    for (int k = 0; k < 4; k++) digit(k, v[4*k +: 4], ~pm[k]);
  endtask

  task automatic do_reset();
    bus_if.AN = 4'hF; bus_if.seg = 7'h7F; bus_if.seg_P = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_seen = '0; m_dat = '0; m_dp = '0;
    p_an = 4'hF; p_g = 7'h00; p_p = 1'b1;
    run = 0; fired = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_dat", 32'(dat), 32'h0);
    chk("reset_dp", 32'(dp), 32'h0);
    step(4'hF, 7'h00, 1'b1, 100);
    chk("idle_fv", 32'(n_fv), 32'd0);
    chk("idle_bad", 32'(n_bad), 32'd0);
    chk("idle_dat", 32'(dat), 32'h0);

    scan(16'h1234, 4'b0000);
    chk("first_frame_cnt", 32'(n_fv), 32'd1);
    chk("first_dat", 32'(dat), 32'h1234);
    chk("first_dp", 32'(dp), 32'h0);
    per_en = 1;
    scan(16'h1234, 4'b0000);
    scan(16'h1234, 4'b0000);
    per_en = 0;
    chk("repeat_frame_cnt", 32'(n_fv), 32'd3);
    chk("repeat_dat", 32'(dat), 32'h1234);

    digit(0, 4'h4, 1'b1);
    digit(1, 4'h3, 1'b1);
    digit(2, 4'h2, 1'b1);
    step(an_of(2), 7'h7F, 1'b1, 5);
    digit(2, 4'h2, 1'b1);
    digit(3, 4'h1, 1'b1);
    chk("glitch_dat", 32'(dat), 32'h1234);
    chk("glitch_bad", 32'(n_bad), 32'(exp_bad));
    scan(16'h1234, 4'b0010);
    chk("dp_digit1", 32'(dp), 32'h2);

    digit(0, 4'h4, 1'b1);
    step(an_of(0), 7'h00, 1'b1, 20);
    chk("invalid_bad", 32'(n_bad), 32'(exp_bad));
    digit(1, 4'h3, 1'b1);
    digit(2, 4'h2, 1'b1);
    digit(3, 4'h1, 1'b1);
    chk("invalid_no_frame", 32'(n_fv), 32'(exp_fv));
    digit(0, 4'hE, 1'b1);
    chk("invalid_recover_dat", 32'(dat), 32'h123E);

    step(4'b1100, gtab[5], 1'b1, 20);
    chk("illegal_an_bad", 32'(n_bad), 32'(exp_bad));
    step(4'b1111, gtab[5], 1'b1, 20);
    chk("blank_an_bad", 32'(n_bad), 32'(exp_bad));

    digit(0, 4'hD, 1'b1);
    digit(1, 4'hC, 1'b1);
    digit(2, 4'hB, 1'b1);
    do_reset();
    chk("midreset_dat", 32'(dat), 32'h0);
    step(4'hF, 7'h00, 1'b1, 20);
    chk("midreset_no_frame", 32'(n_fv), 32'(exp_fv));
    scan(16'hABCD, 4'b0000);
    chk("abcd_dat", 32'(dat), 32'hABCD);

    step(4'hF, 7'h00, 1'b1, 30);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("total_frames", 32'(n_fv), 32'(exp_fv));
    chk("total_bad", 32'(n_bad), 32'(exp_bad));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
